// File: rtl/common.sv
// Shared types for the memory stage of the pipeline.
//
// Contents:
//   REGISTER_WIDTH        - datapath width (32)
//   opcode_t              - major opcodes seen by the memory stage
//   load_funct3_t         - LB/LH/LW/LBU/LHU encodings
//   store_funct3_t        - SB/SH/SW encodings
//   memory_state_t        - memory stage FSM states
//   decoded_instruction_t - decoded instruction fields carried down the pipe
//   execute_to_memory_t   - payload arriving from execute
//   memory_to_writeback_t - payload leaving towards writeback
//   effective_address()   - rs1 + sign-extended I/S immediate
package common;

    localparam int REGISTER_WIDTH = 32;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_RESPONSE,
        OUTPUT
    } memory_state_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] i_type;
        logic [11:0] s_type;
    } decoded_instruction_t;

    typedef struct packed {
        decoded_instruction_t        decoded_instruction;
        logic [REGISTER_WIDTH-1:0]   rs1_value;
        logic [REGISTER_WIDTH-1:0]   rs2_value;
        logic [REGISTER_WIDTH-1:0]   alu_result;
        logic                        branch_taken;
        logic [REGISTER_WIDTH-1:0]   branch_target;
    } execute_to_memory_t;

    typedef struct packed {
        decoded_instruction_t        decoded_instruction;
        logic [REGISTER_WIDTH-1:0]   result;
    } memory_to_writeback_t;

    // Stores encode their offset in the S-type immediate, everything else
    // (loads in particular) in the I-type immediate. Wraps at 32 bits.
    function automatic logic [REGISTER_WIDTH-1:0] effective_address(input execute_to_memory_t p);
        logic [11:0] imm;
        imm = (p.decoded_instruction.opcode == OP_STORE) ? p.decoded_instruction.s_type
                                                         : p.decoded_instruction.i_type;
        return p.rs1_value + {{(REGISTER_WIDTH-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Purely combinational byte-lane logic for the memory stage.
//
// Ports:
//   is_load, is_store - kind of access being aligned
//   funct3            - width/sign selector (LB..LHU / SB..SW)
//   addr_lo           - low two bits of the effective byte address
//   store_value       - rs2 value to be stored
//   load_word         - raw 32-bit word returned by data memory
//   wstrb, wdata      - lane enables and replicated store data
//   load_data         - extracted and extended load result
//   misaligned        - access does not fit its natural alignment
module load_store_align
    import common::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_value,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store data is replicated into every lane so the strobes alone pick
    // where it lands; loads never drive strobes.
    always_comb begin
        wstrb      = 4'b0000;
        wdata      = store_value;
        misaligned = 1'b0;
        if (is_store) begin
            case (funct3)
                SB: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_value[7:0]}};
                end
                SH: begin
                    wstrb      = 4'b0011 << addr_lo;
                    wdata      = {2{store_value[15:0]}};
                    misaligned = addr_lo[0];
                end
                SW: begin
                    wstrb      = 4'b1111;
                    misaligned = (addr_lo != 2'b00);
                end
                default: wstrb = 4'b0000;
            endcase
        end else if (is_load) begin
            case (funct3)
                LH, LHU: misaligned = addr_lo[0];
                LW:      misaligned = (addr_lo != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    lane_byte = load_word[7:0];
            2'd1:    lane_byte = load_word[15:8];
            2'd2:    lane_byte = load_word[23:16];
            default: lane_byte = load_word[31:24];
        endcase
        lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        case (funct3)
            LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
            LBU:     load_data = {24'd0, lane_byte};
            LH:      load_data = {{16{lane_half[15]}}, lane_half};
            LHU:     load_data = {16'd0, lane_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/stage4_memory.sv
// Memory stage: passes ALU results through, or performs one load/store on
// the data-memory request/response port before handing a result onward.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   axis_execute_to_memory_*          - stream in from execute (tvalid/tready/tdata)
//   axis_memory_to_writeback_*        - stream out to writeback (tvalid/tready/tdata)
//   dmem_req_valid/ready              - request handshake
//   dmem_req_write/addr/wdata/wstrb   - request contents (word-aligned address)
//   dmem_rsp_valid/rdata              - load response
//   misaligned_access                 - one-cycle pulse on a misaligned access
module stage4_memory
    import common::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axis_execute_to_memory_tvalid,
    output logic                 axis_execute_to_memory_tready,
    input  execute_to_memory_t   axis_execute_to_memory_tdata,
    output logic                 axis_memory_to_writeback_tvalid,
    input  logic                 axis_memory_to_writeback_tready,
    output memory_to_writeback_t axis_memory_to_writeback_tdata,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic                 dmem_req_write,
    output logic [31:0]          dmem_req_addr,
    output logic [31:0]          dmem_req_wdata,
    output logic [3:0]           dmem_req_wstrb,
    input  logic                 dmem_rsp_valid,
    input  logic [31:0]          dmem_rsp_rdata,
    output logic                 misaligned_access
);

    memory_state_t      state_q, state_d;
    execute_to_memory_t payload_q;
    logic [31:0]        result_q, result_d;
    logic               misaligned_q, misaligned_d;

    logic               in_accept;
    execute_to_memory_t align_src;
    logic [31:0]        align_addr;
    logic               is_load, is_store;
    logic [3:0]         align_wstrb;
    logic [31:0]        align_wdata, align_load_data;
    logic               align_misaligned;
    logic               unused_align_bits;

    assign axis_execute_to_memory_tready = (state_q == IDLE) ||
                                           ((state_q == OUTPUT) && axis_memory_to_writeback_tready);
    assign in_accept = axis_execute_to_memory_tvalid && axis_execute_to_memory_tready;

    // On the accept cycle the decision (memory op? misaligned?) is made on the
    // incoming payload; afterwards the latched payload drives the request and
    // lane extraction, so one aligner serves both.
    assign align_src  = in_accept ? axis_execute_to_memory_tdata : payload_q;
    assign align_addr = effective_address(align_src);
    assign is_load    = (align_src.decoded_instruction.opcode == OP_LOAD);
    assign is_store   = (align_src.decoded_instruction.opcode == OP_STORE);

    assign unused_align_bits = ^{align_src.branch_taken, align_src.branch_target,
                                 align_src.decoded_instruction.rd,
                                 align_src.decoded_instruction.rs1,
                                 align_src.decoded_instruction.rs2};

    load_store_align u_align (
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (align_src.decoded_instruction.funct3),
        .addr_lo     (align_addr[1:0]),
        .store_value (align_src.rs2_value),
        .load_word   (dmem_rsp_rdata),
        .wstrb       (align_wstrb),
        .wdata       (align_wdata),
        .load_data   (align_load_data),
        .misaligned  (align_misaligned)
    );

    assign dmem_req_write = is_store;
    assign dmem_req_addr  = {align_addr[31:2], 2'b00};
    assign dmem_req_wdata = align_wdata;
    assign dmem_req_wstrb = align_wstrb;

    assign axis_memory_to_writeback_tdata.decoded_instruction = payload_q.decoded_instruction;
    assign axis_memory_to_writeback_tdata.result              = result_q;
    assign misaligned_access                                  = misaligned_q;

    // Control state and the misalignment pulse are the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Payload and result registers keep their contents through reset.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            payload_q <= axis_execute_to_memory_tdata;
        end
        result_q <= result_d;
    end

    // A new input can be accepted from IDLE or, back-to-back, from OUTPUT in
    // the same cycle the current result is taken; that accept overrides the
    // per-state next state chosen first.
    always_comb begin
        state_d                         = state_q;
        result_d                        = result_q;
        misaligned_d                    = 1'b0;
        dmem_req_valid                  = 1'b0;
        axis_memory_to_writeback_tvalid = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            REQUEST: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    if (is_store) begin
                        state_d  = OUTPUT;
                        result_d = 32'd0;
                    end else begin
                        state_d = WAIT_RESPONSE;
                    end
                end
            end
            WAIT_RESPONSE: begin
                if (dmem_rsp_valid) begin
                    result_d = align_load_data;
                    state_d  = OUTPUT;
                end
            end
            OUTPUT: begin
                axis_memory_to_writeback_tvalid = 1'b1;
                if (axis_memory_to_writeback_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_accept) begin
            if (is_load || is_store) begin
                if (align_misaligned) begin
                    state_d      = OUTPUT;
                    result_d     = 32'd0;
                    misaligned_d = 1'b1;
                end else begin
                    state_d = REQUEST;
                end
            end else begin
                state_d  = OUTPUT;
                result_d = align_src.alu_result;
            end
        end
    end

endmodule

// File: tb/tb_stage4_memory.sv
// Directed testbench for stage4_memory: pass-through, stores, loads with
// lane extraction, request stalls, output backpressure, back-to-back
// transfers, misalignment and reset mid-transaction.
module tb_stage4_memory;
    import common::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_tvalid;
    logic                 in_tready;
    execute_to_memory_t   in_tdata;
    logic                 out_tvalid;
    logic                 out_tready;
    memory_to_writeback_t out_tdata;
    logic                 dmem_req_valid;
    logic                 dmem_req_ready;
    logic                 dmem_req_write;
    logic [31:0]          dmem_req_addr;
    logic [31:0]          dmem_req_wdata;
    logic [3:0]           dmem_req_wstrb;
    logic                 dmem_rsp_valid;
    logic [31:0]          dmem_rsp_rdata;
    logic                 misaligned_access;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;
    int hs_start;

    always #5 clk = ~clk;

    stage4_memory dut (
        .clk                             (clk),
        .rst                             (rst),
        .axis_execute_to_memory_tvalid   (in_tvalid),
        .axis_execute_to_memory_tready   (in_tready),
        .axis_execute_to_memory_tdata    (in_tdata),
        .axis_memory_to_writeback_tvalid (out_tvalid),
        .axis_memory_to_writeback_tready (out_tready),
        .axis_memory_to_writeback_tdata  (out_tdata),
        .dmem_req_valid                  (dmem_req_valid),
        .dmem_req_ready                  (dmem_req_ready),
        .dmem_req_write                  (dmem_req_write),
        .dmem_req_addr                   (dmem_req_addr),
        .dmem_req_wdata                  (dmem_req_wdata),
        .dmem_req_wstrb                  (dmem_req_wstrb),
        .dmem_rsp_valid                  (dmem_rsp_valid),
        .dmem_rsp_rdata                  (dmem_rsp_rdata),
        .misaligned_access               (misaligned_access)
    );

    // Count completed output transfers to prove single delivery.
    always @(posedge clk) begin
        if (out_tvalid && out_tready) handshakes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // The unused immediate field gets the inverted value so a wrong
    // immediate selection shows up as a wrong address.
    function automatic execute_to_memory_t make_instr(input opcode_t op, input logic [2:0] f3,
                                                      input logic [31:0] rs1, input logic [11:0] imm,
                                                      input logic [31:0] rs2, input logic [31:0] alu);
        execute_to_memory_t p;
        p = '0;
        p.decoded_instruction.opcode = op;
        p.decoded_instruction.funct3 = f3;
        p.decoded_instruction.rd     = 5'd3;
        if (op == OP_STORE) begin
            p.decoded_instruction.s_type = imm;
            p.decoded_instruction.i_type = ~imm;
        end else begin
            p.decoded_instruction.i_type = imm;
            p.decoded_instruction.s_type = ~imm;
        end
        p.rs1_value     = rs1;
        p.rs2_value     = rs2;
        p.alu_result    = alu;
        p.branch_target = 32'h0BAD_0BAD;
        return p;
    endfunction

    // Present one payload for exactly one edge; caller ensures it is accepted.
    task automatic applyStimulus(input execute_to_memory_t p);
        in_tdata  = p;
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
    endtask

    task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [11:0] imm, input logic [31:0] rs2,
                           input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                           input logic [31:0] exp_wdata);
        applyStimulus(make_instr(OP_STORE, f3, rs1, imm, rs2, 32'h5555_5555));
        checkOutput({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
        checkOutput({tag, "_write"},     32'(dmem_req_write), 32'd1);
        checkOutput({tag, "_addr"},      dmem_req_addr, exp_addr);
        checkOutput({tag, "_wstrb"},     32'(dmem_req_wstrb), 32'(exp_wstrb));
        checkOutput({tag, "_wdata"},     dmem_req_wdata, exp_wdata);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checkOutput({tag, "_out_valid"}, 32'(out_tvalid), 32'd1);
        checkOutput({tag, "_result"},    out_tdata.result, 32'd0);
        checkOutput({tag, "_req_done"},  32'(dmem_req_valid), 32'd0);
        tick();
    endtask

    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [11:0] imm, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_result);
        applyStimulus(make_instr(OP_LOAD, f3, rs1, imm, 32'h7777_7777, 32'h6666_6666));
        checkOutput({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
        checkOutput({tag, "_write"},     32'(dmem_req_write), 32'd0);
        checkOutput({tag, "_wstrb"},     32'(dmem_req_wstrb), 32'd0);
        checkOutput({tag, "_addr"},      dmem_req_addr, exp_addr);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checkOutput({tag, "_wait_valid"}, 32'(out_tvalid), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput({tag, "_out_valid"}, 32'(out_tvalid), 32'd1);
        checkOutput({tag, "_result"},    out_tdata.result, exp_result);
        tick();
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst            = 1'b1;
        in_tvalid      = 1'b0;
        in_tdata       = '0;
        out_tready     = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_out_valid",  32'(out_tvalid), 32'd0);
        checkOutput("rst_req_valid",  32'(dmem_req_valid), 32'd0);
        checkOutput("rst_misaligned", 32'(misaligned_access), 32'd0);
        checkOutput("rst_in_ready",   32'(in_tready), 32'd1);

        // Non-memory pass-through
        applyStimulus(make_instr(OP_IMM, 3'd0, 32'd1, 12'd4, 32'd0, 32'h5));
        checkOutput("addi_out_valid", 32'(out_tvalid), 32'd1);
        checkOutput("addi_result",    out_tdata.result, 32'h5);
        checkOutput("addi_no_req",    32'(dmem_req_valid), 32'd0);
        checkOutput("addi_rd",        32'(out_tdata.decoded_instruction.rd), 32'd3);
        tick();
        checkOutput("addi_idle",      32'(out_tvalid), 32'd0);

        // Stores
        doStore("sb",  SB, 32'h1000, 12'd3, 32'h0000_00AB, 32'h1000, 4'b1000, 32'hABAB_ABAB);
        doStore("sh",  SH, 32'h6000, 12'd2, 32'h1234_5678, 32'h6000, 4'b1100, 32'h5678_5678);
        doStore("sw",  SW, 32'h0104, 12'hFFC, 32'hCAFE_F00D, 32'h0100, 4'b1111, 32'hCAFE_F00D);

        // Loads with lane extraction
        doLoad("lb",  LB,  32'h2000, 12'd1, 32'h0000_F000, 32'h2000, 32'hFFFF_FFF0);
        doLoad("lbu", LBU, 32'h2000, 12'd1, 32'h0000_F000, 32'h2000, 32'h0000_00F0);
        doLoad("lh",  LH,  32'h7000, 12'd2, 32'h8001_0000, 32'h7000, 32'hFFFF_8001);
        doLoad("lhu", LHU, 32'h7000, 12'd2, 32'h8001_0000, 32'h7000, 32'h0000_8001);

        // LW with request stalls, response delay and output backpressure
        hs_start = handshakes;
        applyStimulus(make_instr(OP_LOAD, LW, 32'h4000, 12'd8, 32'd0, 32'd0));
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_req_valid", 32'(dmem_req_valid), 32'd1);
            checkOutput("stall_addr",      dmem_req_addr, 32'h4008);
            checkOutput("stall_in_ready",  32'(in_tready), 32'd0);
            tick();
        end
        dmem_req_ready = 1'b1;
        checkOutput("stall_accept_addr", dmem_req_addr, 32'h4008);
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("wait_out_valid", 32'(out_tvalid), 32'd0);
            checkOutput("wait_in_ready",  32'(in_tready), 32'd0);
            checkOutput("wait_req_valid", 32'(dmem_req_valid), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h1234_5678;
        out_tready     = 1'b0;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("lw_out_valid",   32'(out_tvalid), 32'd1);
        checkOutput("lw_result",      out_tdata.result, 32'h1234_5678);
        tick();
        checkOutput("lw_hold_valid",  32'(out_tvalid), 32'd1);
        checkOutput("lw_hold_result", out_tdata.result, 32'h1234_5678);
        checkOutput("lw_hold_ready",  32'(in_tready), 32'd0);
        out_tready = 1'b1;
        tick();
        checkOutput("lw_done",        32'(out_tvalid), 32'd0);
        tick();
        checkOutput("lw_single_out",  32'(handshakes - hs_start), 32'd1);

        // Misaligned LW: no request, pulse, zero result
        applyStimulus(make_instr(OP_LOAD, LW, 32'h3000, 12'd2, 32'd0, 32'h9999_9999));
        checkOutput("mis_pulse",     32'(misaligned_access), 32'd1);
        checkOutput("mis_no_req",    32'(dmem_req_valid), 32'd0);
        checkOutput("mis_out_valid", 32'(out_tvalid), 32'd1);
        checkOutput("mis_result",    out_tdata.result, 32'd0);
        tick();
        checkOutput("mis_pulse_end", 32'(misaligned_access), 32'd0);
        checkOutput("mis_idle",      32'(out_tvalid), 32'd0);

        // Back-to-back pass-through, no bubble
        in_tdata  = make_instr(OP_REG, 3'd0, 32'd0, 12'd0, 32'd0, 32'h11);
        in_tvalid = 1'b1;
        tick();
        checkOutput("b2b_first",     out_tdata.result, 32'h11);
        checkOutput("b2b_in_ready",  32'(in_tready), 32'd1);
        in_tdata = make_instr(OP_REG, 3'd0, 32'd0, 12'd0, 32'd0, 32'h22);
        tick();
        in_tvalid = 1'b0;
        checkOutput("b2b_second_vld", 32'(out_tvalid), 32'd1);
        checkOutput("b2b_second",     out_tdata.result, 32'h22);
        tick();
        checkOutput("b2b_idle",       32'(out_tvalid), 32'd0);

        // Reset during WAIT_RESPONSE; the late response is ignored
        hs_start = handshakes;
        applyStimulus(make_instr(OP_LOAD, LW, 32'h5000, 12'd0, 32'd0, 32'd0));
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rsp_valid = 1'b0;
        checkOutput("rstw_out_valid", 32'(out_tvalid), 32'd0);
        checkOutput("rstw_req_valid", 32'(dmem_req_valid), 32'd0);
        checkOutput("rstw_in_ready",  32'(in_tready), 32'd1);
        tick();
        checkOutput("rstw_no_output", 32'(handshakes - hs_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage4_memory.md
STAGE4_MEMORY -- requirements
Module: stage4_memory

Interface
REQ-001 Parameters: none; widths come from package common (REGISTER_WIDTH = 32).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 axis_execute_to_memory  Axis.in  ExecuteToMemory  from execute: decoded_instruction, rs1_value, rs2_value, alu_result, branch_taken, branch_target.
REQ-005 axis_memory_to_writeback  Axis.out  MemoryToWriteback  to writeback: decoded_instruction, result[31:0].
REQ-006 dmem_req_valid  out  1  data-memory request valid.
REQ-007 dmem_req_ready  in  1  memory accepts request when valid && ready.
REQ-008 dmem_req_write  out  1  1 = store, 0 = load.
REQ-009 dmem_req_addr  out  32  word-aligned byte address (bits [1:0] = 0).
REQ-010 dmem_req_wdata  out  32  lane-aligned store data.
REQ-011 dmem_req_wstrb  out  4  byte-lane write enables; 0 for loads.
REQ-012 dmem_rsp_valid  in  1  load data valid, one pulse per accepted load.
REQ-013 dmem_rsp_rdata  in  32  load word.
REQ-014 misaligned_access  out  1  one-cycle pulse on a misaligned load/store.

Function
REQ-015 Address SHALL be rs1_value + sign-extended immediate (i_type for OP_LOAD, s_type for OP_STORE), 32-bit wrap-around.
REQ-016 FSM states SHALL be IDLE, REQUEST, WAIT_RESPONSE, OUTPUT.
REQ-017 IDLE: input tready = 1; on input tvalid, latch payload; non-memory opcode -> OUTPUT with result = alu_result; load/store -> REQUEST.
REQ-018 REQUEST: dmem_req_valid = 1 with stable addr/write/wdata/wstrb until accepted; load accepted -> WAIT_RESPONSE; store accepted -> OUTPUT with result = 0.
REQ-019 WAIT_RESPONSE: on dmem_rsp_valid, extract lane per funct3 (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word), register result, -> OUTPUT.
REQ-020 OUTPUT: output tvalid = 1, payload stable until tready; on tvalid && tready -> IDLE, or if input tvalid is also present that cycle, latch the next payload directly (back-to-back, no bubble).
REQ-021 Input tready SHALL be 1 only in IDLE, or in OUTPUT when output tready = 1.
REQ-022 Latency: non-memory 1 cycle input-accept to output-valid; store 2 cycles plus request stall cycles; load 2 cycles plus request stall plus response wait.
REQ-023 Store strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; wdata = rs2_value replicated across lanes.
REQ-024 Misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0): no memory request, misaligned_access pulses, go to OUTPUT with result = 0.
REQ-025 dmem_rsp_valid outside WAIT_RESPONSE SHALL be ignored.
REQ-026 Opcodes other than OP_LOAD/OP_STORE SHALL never assert dmem_req_valid.

Reset
REQ-027 On rst: state IDLE; output tvalid, dmem_req_valid, misaligned_access = 0; payload registers unchanged.
REQ-028 rst mid-request or mid-wait SHALL abandon the transaction; a late response is discarded per REQ-025.

Structure
REQ-029 Package common SHALL hold memory_state_t, load/store funct3 enums (LB, LH, LW, LBU, LHU, SB, SH, SW), and the MemoryToWriteback tdata struct.
REQ-030 Sub-module load_store_align SHALL be purely combinational: wstrb/wdata generation, load lane extraction and extension, misalignment detection.

Verification
REQ-031 ADDI result 0x5, output tready = 1 -> output valid next cycle, result 0x5, no dmem request.
REQ-032 SB rs1 = 0x1000, imm = 3, rs2 = 0xAB -> addr 0x1000, wstrb 1000, wdata 0xABABABAB, write = 1.
REQ-033 LB at 0x2001, rdata 0x0000F000 -> result 0xFFFFFFF0; LBU at the same address -> 0x000000F0.
REQ-034 LW with dmem_req_ready low 3 cycles, response 2 cycles later -> request held stable, input tready = 0 throughout, single output.
REQ-035 LW at 0x3002 -> misaligned_access pulse, no request, result 0.
REQ-036 rst asserted in WAIT_RESPONSE, response arrives 1 cycle after rst deasserts -> no output, state IDLE.
